// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL configuration/lock sequencer.
package pll_pkg;

  localparam int P_W = 6;
  localparam int M_W = 10;
  localparam int S_W = 3;

  // Divider values presented to the PLL out of reset.
  localparam logic [P_W-1:0] DEF_P = 6'd1;
  localparam logic [M_W-1:0] DEF_M = 10'd1;
  localparam logic [S_W-1:0] DEF_S = 3'd0;

  // Fixed length of the bypass settle phase before the PLL is reset.
  localparam int BYPASS_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BYPASS   = 3'd1,
    ST_RESET    = 3'd2,
    ST_LOCKWAIT = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_FAIL     = 3'd5
  } pll_state_e;

endpackage

// File: rtl/pll_lock_det.sv
// Phase-detector activity monitor: two-flop synchroniser on up/dn, then
// saturating quiet/active run-length counters with registered done flags.
module pll_lock_det #(
  parameter int LOCK_CYCLES   = 64,
  parameter int UNLOCK_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic up,
  input  logic dn,
  input  logic clr,
  output logic quiet_done,
  output logic active_done
);

  localparam int QW = $clog2(LOCK_CYCLES + 1);
  localparam int AW = $clog2(UNLOCK_CYCLES + 1);
  localparam logic [QW-1:0] Q_MAX = QW'(LOCK_CYCLES);
  localparam logic [AW-1:0] A_MAX = AW'(UNLOCK_CYCLES);

  logic [1:0]    r_up_sync;
  logic [1:0]    r_dn_sync;
  logic [QW-1:0] r_quiet_cnt;
  logic [AW-1:0] r_active_cnt;
  logic          r_quiet_done;
  logic          r_active_done;
  logic          w_act;

  // Bring up/dn into the clkin domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_up_sync <= 2'b00;
      r_dn_sync <= 2'b00;
    end else begin
      r_up_sync <= {r_up_sync[0], up};
      r_dn_sync <= {r_dn_sync[0], dn};
    end
  end

  assign w_act = r_up_sync[1] | r_dn_sync[1];

  // Run-length counters; each restarts on the opposite activity and saturates.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_quiet_cnt  <= '0;
      r_active_cnt <= '0;
    end else begin
      if (w_act)                   r_quiet_cnt <= '0;
      else if (r_quiet_cnt != Q_MAX) r_quiet_cnt <= r_quiet_cnt + 1'b1;
      if (!w_act)                   r_active_cnt <= '0;
      else if (r_active_cnt != A_MAX) r_active_cnt <= r_active_cnt + 1'b1;
    end
  end

  // Threshold compares are registered so the FSM sees a clean flop output.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_quiet_done  <= 1'b0;
      r_active_done <= 1'b0;
    end else begin
      r_quiet_done  <= (r_quiet_cnt == Q_MAX);
      r_active_done <= (r_active_cnt == A_MAX);
    end
  end

  assign quiet_done  = r_quiet_done;
  assign active_done = r_active_done;

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL configuration and lock sequencer.
// Optional build macro: PLL_SEQ_RETRY_EN -- retry RESET/LOCKWAIT up to
// MAX_RETRY extra times after a lock timeout before declaring FAIL.
module pll_seq_ctrl
  import pll_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_CYCLES   = 64,
  parameter int UNLOCK_CYCLES = 8,
  parameter int TIMEOUT       = 4096,
  parameter int MAX_RETRY     = 3
) (
  input  logic           clkin,
  input  logic           rst,
  input  logic           cfg_req,
  input  logic [P_W-1:0] cfg_p,
  input  logic [M_W-1:0] cfg_m,
  input  logic [S_W-1:0] cfg_s,
  output logic           cfg_ack,
  output logic           cfg_err,
  input  logic           up,
  input  logic           dn,
  output logic           pll_rst,
  output logic           pll_en,
  output logic           pll_bypass,
  output logic [P_W-1:0] pll_p,
  output logic [M_W-1:0] pll_m,
  output logic [S_W-1:0] pll_s,
  output logic           locked,
  output logic           busy,
  output logic           fail,
  output logic           lost_lock
);

  localparam int SEQ_W = $clog2(RST_CYCLES + 1);
  localparam logic [SEQ_W-1:0] SEQ_MAX  = SEQ_W'(RST_CYCLES);
  localparam logic [SEQ_W-1:0] BYP_LAST = SEQ_W'(BYPASS_CYCLES - 1);
  localparam logic [SEQ_W-1:0] RST_LAST = SEQ_W'(RST_CYCLES - 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  pll_state_e     r_state, w_state_nxt;
  logic [SEQ_W-1:0] r_seq_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [P_W-1:0] r_p;
  logic [M_W-1:0] r_m;
  logic [S_W-1:0] r_s;
  logic r_ack, r_err, r_lost, r_fail;
  logic w_can_accept, w_cfg_ok, w_accept, w_reject;
  logic w_quiet_done, w_active_done, w_det_clr, w_to_hit;
  logic w_lost, w_retry_inc;

`ifdef PLL_SEQ_RETRY_EN
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RT_W-1:0] r_retry;
`else
  logic w_unused_retry_cfg;
  assign w_unused_retry_cfg = (MAX_RETRY != 0);
`endif

  // Requests are taken only in settled states; the cycle carrying the
  // previous ack/err is skipped so a still-held request is not re-taken.
  assign w_can_accept = cfg_req && !r_ack && !r_err &&
                        (r_state == ST_IDLE || r_state == ST_LOCKED || r_state == ST_FAIL);
  assign w_cfg_ok = (cfg_p != '0) && (cfg_m != '0);
  assign w_accept = w_can_accept && w_cfg_ok;
  assign w_reject = w_can_accept && !w_cfg_ok;
  assign w_to_hit = (r_to_cnt == TO_LAST);

  // Detector counters only run while the PLL is out of reset.
  assign w_det_clr = !(r_state == ST_LOCKWAIT || r_state == ST_LOCKED);

  pll_lock_det #(
    .LOCK_CYCLES  (LOCK_CYCLES),
    .UNLOCK_CYCLES(UNLOCK_CYCLES)
  ) u_lock_det (
    .clk        (clkin),
    .rst        (rst),
    .up         (up),
    .dn         (dn),
    .clr        (w_det_clr),
    .quiet_done (w_quiet_done),
    .active_done(w_active_done)
  );

  // State register.
  always_ff @(posedge clkin) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a valid request overrides everything in accepting states.
  always_comb begin
    w_state_nxt = r_state;
    w_lost      = 1'b0;
    w_retry_inc = 1'b0;
    if (w_accept) begin
      w_state_nxt = ST_BYPASS;
    end else begin
      case (r_state)
        ST_IDLE:     w_state_nxt = ST_IDLE;
        ST_BYPASS:   if (r_seq_cnt == BYP_LAST) w_state_nxt = ST_RESET;
        ST_RESET:    if (r_seq_cnt == RST_LAST) w_state_nxt = ST_LOCKWAIT;
        ST_LOCKWAIT: begin
          if (w_quiet_done) begin
            w_state_nxt = ST_LOCKED;
          end else if (w_to_hit) begin
`ifdef PLL_SEQ_RETRY_EN
            if (r_retry < RT_W'(MAX_RETRY)) begin
              w_state_nxt = ST_RESET;
              w_retry_inc = 1'b1;
            end else begin
              w_state_nxt = ST_FAIL;
            end
`else
            w_state_nxt = ST_FAIL;
`endif
          end
        end
        ST_LOCKED: begin
          if (w_active_done) begin
            w_state_nxt = ST_BYPASS;
            w_lost      = 1'b1;
          end
        end
        ST_FAIL:     w_state_nxt = ST_FAIL;
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Phase timer for BYPASS/RESET; restarts on every state change.
  always_ff @(posedge clkin) begin
    if (rst || (r_state != w_state_nxt)) r_seq_cnt <= '0;
    else if (r_seq_cnt != SEQ_MAX)      r_seq_cnt <= r_seq_cnt + 1'b1;
  end

  // Lock timeout: counts LOCKWAIT cycles of the current attempt.
  always_ff @(posedge clkin) begin
    if (rst || r_state != ST_LOCKWAIT) r_to_cnt <= '0;
    else if (r_to_cnt != TO_MAX)       r_to_cnt <= r_to_cnt + 1'b1;
  end

`ifdef PLL_SEQ_RETRY_EN
  // Retry budget, refilled by each accepted request.
  always_ff @(posedge clkin) begin
    if (rst || w_accept) r_retry <= '0;
    else if (w_retry_inc) r_retry <= r_retry + 1'b1;
  end
`endif

  // Divider registers, handshake pulses and sticky fail flag.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_p    <= DEF_P;
      r_m    <= DEF_M;
      r_s    <= DEF_S;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_lost <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_ack  <= w_accept;
      r_err  <= w_reject;
      r_lost <= w_lost;
      if (w_accept) begin
        r_p    <= cfg_p;
        r_m    <= cfg_m;
        r_s    <= cfg_s;
        r_fail <= 1'b0;
      end else if (w_state_nxt == ST_FAIL) begin
        r_fail <= 1'b1;
      end
    end
  end

  assign cfg_ack    = r_ack;
  assign cfg_err    = r_err;
  assign lost_lock  = r_lost;
  assign fail       = r_fail;
  assign pll_p      = r_p;
  assign pll_m      = r_m;
  assign pll_s      = r_s;
  assign pll_en     = (r_state == ST_LOCKWAIT) || (r_state == ST_LOCKED);
  assign pll_rst    = !pll_en;
  assign pll_bypass = (r_state != ST_LOCKED);
  assign locked     = (r_state == ST_LOCKED);
  assign busy       = (r_state == ST_BYPASS) || (r_state == ST_RESET) ||
                      (r_state == ST_LOCKWAIT);

endmodule
